cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Controller that drives one direct-mapped cache set (single way: synchronous-write data and metadata memories with a combinational hit output) from the CPU fetch side. It performs the lookup, detects misses, issues a single-word read to the memory bus, and writes the returned word and tag into the set. It also sweeps every index invalid after reset and on flush request. It sits between the instruction-fetch port and the backing-memory bus.

## Interface
- DATA_WIDTH, 32, data word width in bits
- TAG_WIDTH, 10, tag width in bits
- INDEX_WIDTH, 6, set index width in bits; the set holds 2^INDEX_WIDTH entries
- i_clock  in  1  clock; all state changes on its rising edge
- i_reset  in  1  reset; asynchronous, active-high
- i_addr  in  TAG_WIDTH+INDEX_WIDTH  CPU word address; {tag, index}, with the index in the LSBs
- i_rd  in  1  CPU read request
- i_flush  in  1  single-cycle pulse that requests invalidation of all entries
- o_data  out  DATA_WIDTH  read data; valid while o_ready=1
- o_ready  out  1  read complete this cycle
- o_busy  out  1  controller is in a flush sweep or a refill
- o_mem_addr  out  TAG_WIDTH+INDEX_WIDTH  memory read address
- o_mem_rd  out  1  memory read request
- i_mem_data  in  DATA_WIDTH  memory data; sampled in the cycle where i_mem_ack=1
- i_mem_ack  in  1  memory data valid
- o_set_index  out  INDEX_WIDTH  set index
- o_set_tag  out  TAG_WIDTH  set tag
- o_set_data  out  DATA_WIDTH  set write data
- o_set_wr  out  1  set write (fill)
- o_set_cl  out  1  set invalidate
- i_set_data  in  DATA_WIDTH  set read data; combinational from o_set_index
- i_set_hit  in  1  set hit; combinational, and 0 while o_set_wr or o_set_cl is 1

## Operation
- States: FLUSH, LOOKUP, MISS, FILL.
- FLUSH:
  - Drives o_set_cl=1 and o_set_index=sweep counter.
  - The counter increments from 0 to 2^INDEX_WIDTH-1.
  - After the last index it goes to LOOKUP and clears the counter.
  - o_busy=1 and o_ready=0 throughout.
  - i_rd and i_mem_ack are ignored.
- LOOKUP:
  - Drives o_set_index and o_set_tag from i_addr.
  - o_ready = i_rd & i_set_hit; o_data = i_set_data.
  - If i_rd=1 and i_set_hit=0: latch i_addr into the miss register and go to MISS.
  - If i_flush=1: go to FLUSH. Flush takes priority over a miss in the same cycle; the read retries after the sweep.
- MISS:
  - Drives o_mem_rd=1 and o_mem_addr=latched address; both are held stable until i_mem_ack.
  - On i_mem_ack: latch i_mem_data and go to FILL.
- FILL (one cycle):
  - Drives o_set_wr=1, with o_set_index, o_set_tag and o_set_data taken from the latched values.
  - Then goes to FLUSH if a flush is pending, else to LOOKUP.
- o_busy=1 in FLUSH, MISS and FILL.
- o_ready=0 outside LOOKUP.
- i_flush seen in MISS or FILL sets a pending flag. The flag is consumed when FILL exits to FLUSH.
- The CPU holds i_addr stable while i_rd=1 and o_ready=0. If i_rd drops during MISS, the refill still completes and the entry is written.
- o_set_wr and o_set_cl are never 1 together.
- When the controller is not in MISS, o_mem_addr = 0.

## Timing
- Reset (asynchronous) forces the following immediately, and the sweep starts on the first edge after release:
  - state=FLUSH, counter=0, pending flush=0
  - o_set_cl=1, o_set_index=0, o_busy=1
  - o_ready=0, o_set_wr=0, o_mem_rd=0, o_mem_addr=0
- Reset mid-refill: o_mem_rd drops at once. A late i_mem_ack is ignored, because FLUSH ignores it.
- Sweep length is exactly 2^INDEX_WIDTH cycles. The first LOOKUP follows in the next cycle.
- Hit latency is 0 cycles: o_ready is asserted in the same cycle as i_rd.
- Back-to-back hits complete one per cycle.
- Miss latency is 1 (LOOKUP) + N (MISS, N≥1 up to and including the ack cycle) + 1 (FILL) + 1 (LOOKUP hit) = N+3 cycles from i_rd to o_ready.

## Configuration
- CACHE_STATS_EN: compiles in two extra outputs:
  - o_hits  out  32: count of LOOKUP cycles with o_ready=1
  - o_misses  out  32: count of LOOKUP-to-MISS transitions
- Both counters saturate at 2^32-1.
- Both counters are cleared by reset only; a flush does not clear them.
- The hit that follows a refill counts as a hit as well.
- Without CACHE_STATS_EN, the ports and counters do not exist and behaviour is otherwise identical.

## Test plan
- Reset sweep: release reset with INDEX_WIDTH=6 -> o_set_cl=1 for 64 cycles with index 0..63. o_busy falls in cycle 65.
- Cold miss: i_rd with i_addr=0x155, memory acks after 3 cycles with 0xDEADBEEF:
  - o_mem_addr=0x155
  - one o_set_wr cycle with index 0x15, tag 0x5
  - o_ready with o_data=0xDEADBEEF at cycle 6
- Repeat hit: read 0x155 again -> o_ready in the same cycle with no o_mem_rd. Four consecutive hits take 4 cycles.
- Conflict: read 0x255 after 0x155 (same index, tag 0x9) -> miss and refill. A following read of 0x155 misses again.
- Flush during miss: pulse i_flush in the MISS cycle -> fill completes, then a 64-cycle sweep. The next read of 0x255 misses.
- Reset mid-miss: assert i_reset while o_mem_rd=1 and ack 2 cycles later -> o_mem_rd=0 at once, no o_set_wr, and a full sweep. With CACHE_STATS_EN, o_hits=o_misses=0.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// ============================================================================
// Module   : cache_refill_ctrl
// Brief    : Lookup / miss / refill / flush-sweep controller for one
//            direct-mapped cache set. Optional hit/miss counters are compiled
//            in with the CACHE_STATS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_refill_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 10,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [TAG_WIDTH+INDEX_WIDTH-1:0] i_addr,
  input  logic                             i_rd,
  input  logic                             i_flush,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_ready,
  output logic                             o_busy,
  output logic [TAG_WIDTH+INDEX_WIDTH-1:0] o_mem_addr,
  output logic                             o_mem_rd,
  input  logic [DATA_WIDTH-1:0]            i_mem_data,
  input  logic                             i_mem_ack,
  output logic [INDEX_WIDTH-1:0]           o_set_index,
  output logic [TAG_WIDTH-1:0]             o_set_tag,
  output logic [DATA_WIDTH-1:0]            o_set_data,
  output logic                             o_set_wr,
  output logic                             o_set_cl,
  input  logic [DATA_WIDTH-1:0]            i_set_data,
  input  logic                             i_set_hit
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                      o_hits,
  output logic [31:0]                      o_misses
`endif
);

  localparam int AW = TAG_WIDTH + INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_MISS   = 2'd2,
    ST_FILL   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [AW-1:0]          miss_addr_q, miss_addr_d;
  logic [DATA_WIDTH-1:0]  fill_data_q, fill_data_d;
  logic                   lookup_hit;
  logic                   lookup_miss;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_FLUSH;
      sweep_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      miss_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      flush_pend_q <= flush_pend_d;
      miss_addr_q  <= miss_addr_d;
      fill_data_q  <= fill_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    flush_pend_d = flush_pend_q;
    miss_addr_d  = miss_addr_q;
    fill_data_d  = fill_data_q;
    lookup_hit   = 1'b0;
    lookup_miss  = 1'b0;

    o_data      = '0;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_mem_addr  = '0;
    o_mem_rd    = 1'b0;
    o_set_index = '0;
    o_set_tag   = '0;
    o_set_data  = '0;
    o_set_wr    = 1'b0;
    o_set_cl    = 1'b0;

    case (state_q)
      ST_FLUSH: begin
        o_busy      = 1'b1;
        o_set_cl    = 1'b1;
        o_set_index = sweep_cnt_q;
        if (sweep_cnt_q == {INDEX_WIDTH{1'b1}}) begin
          sweep_cnt_d = '0;
          state_d     = ST_LOOKUP;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end

      ST_LOOKUP: begin
        o_set_index = i_addr[INDEX_WIDTH-1:0];
        o_set_tag   = i_addr[AW-1:INDEX_WIDTH];
        o_data      = i_set_data;
        lookup_hit  = i_rd & i_set_hit;
        o_ready     = lookup_hit;
        // A flush wins over a miss; the CPU keeps i_rd high and retries later.
        if (i_flush) begin
          state_d = ST_FLUSH;
        end else if (i_rd && !i_set_hit) begin
          lookup_miss = 1'b1;
          miss_addr_d = i_addr;
          state_d     = ST_MISS;
        end
      end

      ST_MISS: begin
        o_busy     = 1'b1;
        o_mem_rd   = 1'b1;
        o_mem_addr = miss_addr_q;
        if (i_flush) begin
          flush_pend_d = 1'b1;
        end
        if (i_mem_ack) begin
          fill_data_d = i_mem_data;
          state_d     = ST_FILL;
        end
      end

      ST_FILL: begin
        o_busy      = 1'b1;
        o_set_wr    = 1'b1;
        o_set_index = miss_addr_q[INDEX_WIDTH-1:0];
        o_set_tag   = miss_addr_q[AW-1:INDEX_WIDTH];
        o_set_data  = fill_data_q;
        // A flush arriving in this very cycle is folded into the pending flag.
        if (flush_pend_q || i_flush) begin
          flush_pend_d = 1'b0;
          state_d      = ST_FLUSH;
        end else begin
          state_d      = ST_LOOKUP;
        end
      end

      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (lookup_hit && (hits_q != 32'hFFFF_FFFF)) begin
      hits_d = hits_q + 32'd1;
    end
    if (lookup_miss && (misses_q != 32'hFFFF_FFFF)) begin
      misses_d = misses_q + 32'd1;
    end
  end

  assign o_hits   = hits_q;
  assign o_misses = misses_q;
`else
  // Without the statistics option the hit/miss strobes have no consumer.
  logic stats_unused;
  assign stats_unused = lookup_hit ^ lookup_miss;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Brief    : Directed self-checking bench for cache_refill_ctrl with a
//            behavioural single-way set model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_refill_ctrl;

  localparam int DW = 32;
  localparam int TW = 10;
  localparam int IW = 6;
  localparam int AW = TW + IW;
  localparam int NSETS = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_addr;
  logic          i_rd;
  logic          i_flush;
  logic [DW-1:0] o_data;
  logic          o_ready;
  logic          o_busy;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd;
  logic [DW-1:0] i_mem_data;
  logic          i_mem_ack;
  logic [IW-1:0] o_set_index;
  logic [TW-1:0] o_set_tag;
  logic [DW-1:0] o_set_data;
  logic          o_set_wr;
  logic          o_set_cl;
  logic [DW-1:0] i_set_data;
  logic          i_set_hit;
`ifdef CACHE_STATS_EN
  logic [31:0]   o_hits;
  logic [31:0]   o_misses;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .INDEX_WIDTH(IW)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .i_flush    (i_flush),
    .o_data     (o_data),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_mem_addr (o_mem_addr),
    .o_mem_rd   (o_mem_rd),
    .i_mem_data (i_mem_data),
    .i_mem_ack  (i_mem_ack),
    .o_set_index(o_set_index),
    .o_set_tag  (o_set_tag),
    .o_set_data (o_set_data),
    .o_set_wr   (o_set_wr),
    .o_set_cl   (o_set_cl),
    .i_set_data (i_set_data),
    .i_set_hit  (i_set_hit)
`ifdef CACHE_STATS_EN
    ,
    .o_hits     (o_hits),
    .o_misses   (o_misses)
`endif
  );

  // Behavioural set: synchronous write/invalidate, combinational read/hit.
  logic          m_valid [NSETS];
  logic [TW-1:0] m_tag   [NSETS];
  logic [DW-1:0] m_data  [NSETS];

  initial begin
    for (int i = 0; i < NSETS; i++) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = TW'(i);
      m_data[i]  = 32'hBAD0_0000 | DW'(i);
    end
  end

  always @(posedge clk) begin
    if (o_set_wr) begin
      m_valid[o_set_index] <= 1'b1;
      m_tag[o_set_index]   <= o_set_tag;
      m_data[o_set_index]  <= o_set_data;
    end else if (o_set_cl) begin
      m_valid[o_set_index] <= 1'b0;
    end
  end

  always_comb begin
    i_set_data = m_data[o_set_index];
    i_set_hit  = m_valid[o_set_index] && (m_tag[o_set_index] == o_set_tag)
                 && !o_set_wr && !o_set_cl;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts just after a posedge in FLUSH with counter 0; checks the whole sweep.
  task automatic sweep_check(input string tag, input bit ack_pulse);
    int cl_n = 0;
    int bad  = 0;
    int wr_n = 0;
    int nb   = 0;
    for (int k = 0; k < NSETS; k++) begin
      @(negedge clk);
      if (ack_pulse && k == 0) begin
        i_mem_ack  = 1'b1;
        i_mem_data = 32'hFFFF_FFFF;
      end else begin
        i_mem_ack = 1'b0;
      end
      #1;
      if (o_set_cl) cl_n++;
      if (o_set_index != IW'(k)) bad++;
      if (o_set_wr) wr_n++;
      if (!o_busy || o_ready || o_mem_rd) nb++;
    end
    @(negedge clk);
    i_mem_ack = 1'b0;
    #1;
    check({tag, "_cl_cycles"}, cl_n, NSETS);
    check({tag, "_index_seq"}, bad, 0);
    check({tag, "_no_wr"}, wr_n, 0);
    check({tag, "_busy_hold"}, nb, 0);
    check({tag, "_busy_drop"}, {o_busy, o_set_cl}, 2'b00);
    check({tag, "_mem_addr_idle"}, o_mem_addr, 0);
  endtask

  // One CPU read held until o_ready; acts as the memory, acking on the
  // n_ack-th cycle of every MISS episode.
  task automatic do_read(input logic [AW-1:0] addr, input int n_ack,
                         input logic [DW-1:0] mdata, input bit flush_in_miss,
                         output int lat, output int mem_eps, output logic [AW-1:0] maddr,
                         output int wr_n, output logic [IW-1:0] widx,
                         output logic [TW-1:0] wtag, output logic [DW-1:0] wdata,
                         output int cl_n, output logic [DW-1:0] rdata);
    int ep_cnt = 0;
    bit done = 0;
    lat = 0; mem_eps = 0; maddr = '0; wr_n = 0; widx = '0; wtag = '0;
    wdata = '0; cl_n = 0; rdata = '0;
    @(negedge clk);
    i_addr = addr;
    i_rd   = 1'b1;
    while (!done && lat < 300) begin
      lat++;
      i_mem_ack = 1'b0;
      i_flush   = 1'b0;
      #1;
      if (o_ready) begin
        rdata = o_data;
        done  = 1;
      end else begin
        if (o_mem_rd) begin
          if (ep_cnt == 0) mem_eps++;
          ep_cnt++;
          maddr = o_mem_addr;
          if (flush_in_miss && mem_eps == 1 && ep_cnt == 1) i_flush = 1'b1;
          if (ep_cnt == n_ack) begin
            i_mem_ack  = 1'b1;
            i_mem_data = mdata;
          end
        end else begin
          ep_cnt = 0;
        end
        if (o_set_wr) begin
          wr_n++;
          widx  = o_set_index;
          wtag  = o_set_tag;
          wdata = o_set_data;
        end
        if (o_set_cl) cl_n++;
      end
      @(negedge clk);
    end
    i_rd      = 1'b0;
    i_mem_ack = 1'b0;
    i_flush   = 1'b0;
    check("read_completed", done, 1);
  endtask

  int            lat, eps, wr_n, cl_n, nrdy, nmem;
  logic [AW-1:0] maddr;
  logic [IW-1:0] widx;
  logic [TW-1:0] wtag;
  logic [DW-1:0] wdata, rdata;

  initial begin
    rst        = 1'b1;
    i_addr     = '0;
    i_rd       = 1'b0;
    i_flush    = 1'b0;
    i_mem_data = '0;
    i_mem_ack  = 1'b0;
    #1;
    check("reset_outputs",
          {o_set_cl, o_busy, o_ready, o_set_wr, o_mem_rd},
          5'b11000);
    check("reset_index", o_set_index, 0);
    check("reset_mem_addr", o_mem_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    sweep_check("reset_sweep", 1'b0);

    // Cold miss: 0x155 -> index 0x15, tag 0x5, ack on 3rd MISS cycle.
    do_read(16'h0155, 3, 32'hDEAD_BEEF, 1'b0, lat, eps, maddr, wr_n, widx, wtag, wdata, cl_n, rdata);
    check("cold_latency", lat, 6);
    check("cold_mem_addr", maddr, 16'h0155);
    check("cold_mem_episodes", eps, 1);
    check("cold_wr_cycles", wr_n, 1);
    check("cold_wr_index", widx, 6'h15);
    check("cold_wr_tag", wtag, 10'h005);
    check("cold_wr_data", wdata, 32'hDEAD_BEEF);
    check("cold_rdata", rdata, 32'hDEAD_BEEF);

    // Repeat hit, zero latency.
    do_read(16'h0155, 1, 32'h0, 1'b0, lat, eps, maddr, wr_n, widx, wtag, wdata, cl_n, rdata);
    check("hit_latency", lat, 1);
    check("hit_no_mem", eps, 0);
    check("hit_rdata", rdata, 32'hDEAD_BEEF);

    // Four back-to-back hits in four cycles.
    nrdy = 0; nmem = 0;
    @(negedge clk);
    i_addr = 16'h0155;
    i_rd   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (o_ready && o_data == 32'hDEAD_BEEF) nrdy++;
      if (o_mem_rd) nmem++;
      @(negedge clk);
    end
    i_rd = 1'b0;
    check("b2b_hits", nrdy, 4);
    check("b2b_no_mem", nmem, 0);

    // Conflict miss on the same index with tag 0x9, then 0x155 misses again.
    do_read(16'h0255, 1, 32'hCAFE_F00D, 1'b0, lat, eps, maddr, wr_n, widx, wtag, wdata, cl_n, rdata);
    check("conflict_latency", lat, 4);
    check("conflict_wr_tag", wtag, 10'h009);
    check("conflict_wr_index", widx, 6'h15);
    check("conflict_rdata", rdata, 32'hCAFE_F00D);
    do_read(16'h0155, 2, 32'h1234_5678, 1'b0, lat, eps, maddr, wr_n, widx, wtag, wdata, cl_n, rdata);
    check("evicted_latency", lat, 5);
    check("evicted_rdata", rdata, 32'h1234_5678);

    // Flush in the first MISS cycle: fill, 64-cycle sweep, then 0x255 misses again.
    do_read(16'h0255, 2, 32'hA5A5_0F0F, 1'b1, lat, eps, maddr, wr_n, widx, wtag, wdata, cl_n, rdata);
    check("flushmiss_latency", lat, 73);
    check("flushmiss_cl_cycles", cl_n, 64);
    check("flushmiss_mem_episodes", eps, 2);
    check("flushmiss_wr_cycles", wr_n, 2);
    check("flushmiss_rdata", rdata, 32'hA5A5_0F0F);

`ifdef CACHE_STATS_EN
    check("stats_hits", o_hits, 9);
    check("stats_misses", o_misses, 5);
`endif

    // Reset while a refill is outstanding; a late ack lands in the sweep.
    @(negedge clk);
    i_addr = 16'h0155;
    i_rd   = 1'b1;
    @(negedge clk);
    #1;
    check("rstmiss_mem_rd", o_mem_rd, 1);
    check("rstmiss_mem_addr", o_mem_addr, 16'h0155);
    rst = 1'b1;
    #1;
    check("rstmiss_async_outputs",
          {o_mem_rd, o_set_wr, o_set_cl, o_busy, o_ready},
          5'b00110);
    check("rstmiss_mem_addr_cleared", o_mem_addr, 0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    i_rd = 1'b0;
    sweep_check("rstmiss_sweep", 1'b1);
`ifdef CACHE_STATS_EN
    check("rstmiss_stats", {o_hits, o_misses}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
